sysbus: RTL and testbench
=========================

SYSBUS -- requirements
Module: sysbus

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting for bus_ack before abort.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 inst_addr  input  32  fetch address from pc.
REQ-005 inst_o  output  32  fetched instruction, registered.
REQ-006 inst_vld_o  output  1  one-cycle pulse, inst_o updated.
REQ-007 mem_re  input  1  load request from executrol.
REQ-008 mem_we  input  1  store request from executrol.
REQ-009 addr  input  32  data byte address.
REQ-010 byte_mask  input  4  access size: 4'h1 byte, 4'h3 half, 4'hF word.
REQ-011 un_sign  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-012 wdata  input  32  store data, right-aligned.
REQ-013 rdata_o  output  32  extended load data, registered.
REQ-014 rdata_vld_o  output  1  one-cycle pulse, rdata_o updated.
REQ-015 hold_o  output  1  stall to pipeline while a data access is pending.
REQ-016 err_o  output  1  one-cycle pulse on misalignment or timeout.
REQ-017 bus_req_o / bus_we_o  output  1 / 1  memory request, write qualifier.
REQ-018 bus_addr_o  output  32  word-aligned address ([1:0]=0).
REQ-019 bus_be_o  output  4  byte enables (writes); 4'hF on reads.
REQ-020 bus_wdata_o  output  32  lane-aligned store data.
REQ-021 bus_ack  input  1  transfer complete, sampled on clk edge while bus_req_o=1.
REQ-022 bus_rdata  input  32  read word, valid with bus_ack.

Function
REQ-023 FSM states IDLE, FETCH, LOAD, STORE; one bus transaction at a time.
REQ-024 IDLE: mem_re -> LOAD; else mem_we -> STORE; else FETCH (data priority over fetch; mem_re and mem_we together = LOAD, store dropped, err_o pulse).
REQ-025 Address, be, wdata, sign/size latched on entry to a bus state; input changes mid-transaction ignored.
REQ-026 bus_req_o high in FETCH/LOAD/STORE until ack edge; return to IDLE on that edge; min latency 1 cycle, back-to-back requests separated by one IDLE cycle.
REQ-027 FETCH ack: inst_o <= bus_rdata, inst_vld_o pulse next cycle.
REQ-028 LOAD ack: select lane by addr[1:0], extend per un_sign, rdata_o <= result, rdata_vld_o pulse.
REQ-029 STORE: bus_be_o = byte_mask << addr[1:0]; bus_wdata_o = wdata << 8*addr[1:0].
REQ-030 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus request, err_o pulse, hold_o released next cycle, rdata_o unchanged.
REQ-031 hold_o = 1 combinationally when (mem_re|mem_we) and data access not completing this cycle; 0 in ack cycle.
REQ-032 Wait counter 8-bit, cleared on state entry; reaching TIMEOUT -> drop bus_req_o, IDLE, err_o pulse, no vld pulse.
REQ-033 bus_ack while bus_req_o=0 ignored.

Reset
REQ-034 rst low: state IDLE, counter 0, all outputs 0 (inst_o=0, rdata_o=0, bus_req_o=0, hold_o=0) immediately, mid-transaction included; first request issued on first edge after deassertion.

Structure
REQ-035 Shared package sysbus_pkg: state enum, MASK_BYTE/HALF/WORD constants, TIMEOUT default.
REQ-036 One combinational sub-module sysbus_align: load extract/extend and store lane shift.

Verification
REQ-037 Fetch: inst_addr=0x100, ack after 2 cycles, rdata=0x00A00093 -> bus_addr_o=0x100, inst_o=0x00A00093, one inst_vld_o pulse.
REQ-038 Signed byte load addr=0x203, bus_rdata=0x80FFFFFF -> rdata_o=0xFFFFFF80; un_sign=1 -> 0x00000080.
REQ-039 Half store addr=0x302, wdata=0x1234 -> bus_be_o=4'hC, bus_wdata_o=0x12340000, hold_o until ack.
REQ-040 Word load addr=0x401 -> err_o pulse, bus_req_o never high, hold_o low next cycle.
REQ-041 Load during pending fetch, no ack for 255 cycles -> err_o, IDLE, then load issued with data priority.
REQ-042 rst low mid-STORE -> bus_req_o and hold_o 0 in same cycle; normal fetch after release.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared state encoding, access-size masks and defaults for the sysbus
// instruction/data bus interface unit.
package sysbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        STORE
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'h1;
    localparam logic [3:0] MASK_HALF = 4'h3;
    localparam logic [3:0] MASK_WORD = 4'hF;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    function automatic logic misaligned(input logic [1:0] lane, input logic [3:0] mask);
        return ((mask == MASK_HALF) && lane[0]) || ((mask == MASK_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/sysbus_align.sv
// Byte-lane steering: load lane extract with sign/zero extension and
// store lane shift with byte-enable generation.
module sysbus_align
    import sysbus_pkg::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [3:0]  ld_mask_i,
    input  logic        ld_unsigned_i,
    output logic [31:0] ld_data_o,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  st_lane_i,
    input  logic [3:0]  st_mask_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o
);

    logic [31:0] lane_word;

    always_comb begin
        lane_word = ld_word_i >> {ld_lane_i, 3'b000};
        case (ld_mask_i)
            MASK_BYTE: ld_data_o = {{24{~ld_unsigned_i & lane_word[7]}}, lane_word[7:0]};
            MASK_HALF: ld_data_o = {{16{~ld_unsigned_i & lane_word[15]}}, lane_word[15:0]};
            default:   ld_data_o = ld_word_i;
        endcase
        st_be_o   = st_mask_i << st_lane_i;
        st_data_o = st_data_i << {st_lane_i, 3'b000};
    end

endmodule

// File: rtl/sysbus.sv
// Single-transaction bus interface unit arbitrating instruction fetch and
// data load/store onto one request/ack memory bus, with wait timeout.
module sysbus
    import sysbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_o,
    output logic        inst_vld_o,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] addr,
    input  logic [3:0]  byte_mask,
    input  logic        un_sign,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_o,
    output logic        rdata_vld_o,
    output logic        hold_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        uns_q, uns_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_vld_q, inst_vld_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_vld_q, rdata_vld_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic [31:0] ld_data;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        data_req;
    logic        data_state;

    assign data_req   = mem_re | mem_we;
    assign data_state = (state_q == LOAD) || (state_q == STORE);

    sysbus_align u_align (
        .ld_word_i     (bus_rdata),
        .ld_lane_i     (addr_q[1:0]),
        .ld_mask_i     (mask_q),
        .ld_unsigned_i (uns_q),
        .ld_data_o     (ld_data),
        .st_data_i     (wdata),
        .st_lane_i     (addr[1:0]),
        .st_mask_i     (byte_mask),
        .st_be_o       (st_be),
        .st_data_o     (st_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            uns_q       <= 1'b0;
            inst_q      <= '0;
            inst_vld_q  <= 1'b0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            uns_q       <= uns_d;
            inst_q      <= inst_d;
            inst_vld_q  <= inst_vld_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
            err_q       <= err_d;
            mis_q       <= mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 8'd1;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        uns_d       = uns_q;
        inst_d      = inst_q;
        inst_vld_d  = 1'b0;
        rdata_d     = rdata_q;
        rdata_vld_d = 1'b0;
        err_d       = 1'b0;
        mis_d       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A rejected misaligned access completes here: release the stall, issue nothing.
                if (mis_q) begin
                    state_d = IDLE;
                end else if (data_req) begin
                    err_d = mem_re & mem_we;
                    if (misaligned(addr[1:0], byte_mask)) begin
                        err_d = 1'b1;
                        mis_d = 1'b1;
                    end else begin
                        state_d = mem_re ? LOAD : STORE;
                        addr_d  = addr;
                        be_d    = mem_re ? MASK_WORD : st_be;
                        wdata_d = st_data;
                        mask_d  = byte_mask;
                        uns_d   = un_sign;
                    end
                end else begin
                    state_d = FETCH;
                    addr_d  = inst_addr;
                    be_d    = MASK_WORD;
                end
            end
            default: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    if (state_q == FETCH) begin
                        inst_d     = bus_rdata;
                        inst_vld_d = 1'b1;
                    end else if (state_q == LOAD) begin
                        rdata_d     = ld_data;
                        rdata_vld_d = 1'b1;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    assign bus_req_o   = (state_q != IDLE);
    assign bus_we_o    = (state_q == STORE);
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign inst_o      = inst_q;
    assign inst_vld_o  = inst_vld_q;
    assign rdata_o     = rdata_q;
    assign rdata_vld_o = rdata_vld_q;
    assign err_o       = err_q;
    // Gated by rst so the stall drops in the same cycle reset is applied.
    assign hold_o      = rst & data_req & ~mis_q & ~(data_state & bus_ack);

endmodule

// File: tb/tb_sysbus.sv
// Self-checking bench for sysbus: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sysbus;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic [31:0] inst_o;
    logic        inst_vld_o;
    logic        mem_re, mem_we;
    logic [31:0] addr;
    logic [3:0]  byte_mask;
    logic        un_sign;
    logic [31:0] wdata;
    logic [31:0] rdata_o;
    logic        rdata_vld_o, hold_o, err_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    sysbus #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr   (inst_addr),
        .inst_o      (inst_o),
        .inst_vld_o  (inst_vld_o),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .addr        (addr),
        .byte_mask   (byte_mask),
        .un_sign     (un_sign),
        .wdata       (wdata),
        .rdata_o     (rdata_o),
        .rdata_vld_o (rdata_vld_o),
        .hold_o      (hold_o),
        .err_o       (err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record plus pending pulses.
    bit          m_busy, m_fetch, m_write, m_cool;
    logic [31:0] m_addr, m_wdata, m_inst, m_rdata;
    logic [3:0]  m_mask;
    bit          m_uns;
    int unsigned m_wait;
    bit          m_ivld, m_rvld, m_err;

    function automatic bit tb_misaligned(input logic [31:0] a, input logic [3:0] m);
        return (m == 4'h3 && (a % 2) != 0) || (m == 4'hF && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] word, input int unsigned lane,
                                               input logic [3:0] m, input bit uns);
        logic [31:0] v;
        if (m == 4'h1) begin
            v = (word >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (m == 4'h3) begin
            v = (word >> (8 * lane)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ctrl", {26'd0, bus_req_o, bus_we_o, hold_o, err_o, inst_vld_o, rdata_vld_o}, 32'd0);
            chk("rst_inst", inst_o, 32'd0);
            chk("rst_rdata", rdata_o, 32'd0);
            chk("rst_bus_addr", bus_addr_o, 32'd0);
            m_busy = 0; m_cool = 0; m_ivld = 0; m_rvld = 0; m_err = 0;
            m_inst = '0; m_rdata = '0;
        end else begin
            int unsigned lane;
            logic [3:0]  ebe;
            lane = m_addr % 4;
            ebe  = m_write ? 4'((m_mask * (1 << lane)) % 16) : 4'hF;
            chk("bus_req", bus_req_o, m_busy);
            chk("bus_we", bus_we_o, m_busy && m_write);
            if (m_busy) begin
                chk("bus_addr", bus_addr_o, m_addr - lane);
                chk("bus_be", bus_be_o, ebe);
                if (m_write) chk("bus_wdata", bus_wdata_o, m_wdata << (8 * lane));
            end
            chk("inst", inst_o, m_inst);
            chk("inst_vld", inst_vld_o, m_ivld);
            chk("rdata", rdata_o, m_rdata);
            chk("rdata_vld", rdata_vld_o, m_rvld);
            chk("err", err_o, m_err);
            chk("hold", hold_o, (mem_re || mem_we) && !m_cool && !(m_busy && !m_fetch && bus_ack));

            m_ivld = 0; m_rvld = 0; m_err = 0;
            if (m_busy) begin
                if (bus_ack) begin
                    m_busy = 0;
                    if (m_fetch) begin
                        m_inst = bus_rdata;
                        m_ivld = 1;
                    end else if (!m_write) begin
                        m_rdata = load_value(bus_rdata, lane, m_mask, m_uns);
                        m_rvld  = 1;
                    end
                end else if (m_wait + 1 == TO) begin
                    m_busy = 0;
                    m_err  = 1;
                end else begin
                    m_wait++;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (mem_re || mem_we) begin
                m_err = mem_re && mem_we;
                if (tb_misaligned(addr, byte_mask)) begin
                    m_err  = 1;
                    m_cool = 1;
                end else begin
                    m_busy  = 1; m_fetch = 0; m_write = !mem_re; m_wait = 0;
                    m_addr  = addr; m_mask = byte_mask; m_uns = un_sign; m_wdata = wdata;
                end
            end else begin
                m_busy = 1; m_fetch = 1; m_write = 0; m_wait = 0;
                m_addr = inst_addr;
            end
        end
    end

    task automatic cyc(input bit re, input bit we, input logic [31:0] a, input logic [3:0] m,
                       input bit us, input logic [31:0] wd, input bit ack, input logic [31:0] rd);
        @(posedge clk); #1;
        mem_re = re; mem_we = we; addr = a; byte_mask = m; un_sign = us;
        wdata = wd; bus_ack = ack; bus_rdata = rd;
        @(negedge clk);
    endtask

    task automatic idle_cyc(input bit ack, input logic [31:0] rd);
        cyc(0, 0, 32'h0, 4'hF, 0, 32'h0, ack, rd);
    endtask

    // Ends in a cycle whose successor is guaranteed to be IDLE.
    task automatic sync_idle();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle_cyc(1, 32'h0000_0013);
            if (bus_req_o) found = 1;
        end
        if (!found) chk("sync_idle_bound", bus_req_o, 1);
    endtask

    logic [3:0] masks [3] = '{4'h1, 4'h3, 4'hF};

    initial begin
        rst = 1'b1;
        inst_addr = 32'h100; mem_re = 0; mem_we = 0; addr = 0; byte_mask = 4'hF;
        un_sign = 0; wdata = 0; bus_ack = 0; bus_rdata = 0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Fetch after reset release, ack on the second bus cycle
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("fetch_idle_req", bus_req_o, 0);
        idle_cyc(0, 32'h0);
        chk("fetch_req", bus_req_o, 1);
        chk("fetch_addr", bus_addr_o, 32'h100);
        idle_cyc(1, 32'h00A00093);
        chk("fetch_vld_early", inst_vld_o, 0);
        idle_cyc(0, 32'h0);
        chk("fetch_inst", inst_o, 32'h00A00093);
        chk("fetch_vld", inst_vld_o, 1);
        idle_cyc(1, 32'h0000_0013);
        chk("fetch_vld_pulse", inst_vld_o, 0);

        // Signed and unsigned byte loads from lane 3
        for (int u = 0; u < 2; u++) begin
            sync_idle();
            cyc(1, 0, 32'h203, 4'h1, u[0], 32'h0, 0, 32'h0);
            chk("ldb_hold_wait", hold_o, 1);
            chk("ldb_req_idle", bus_req_o, 0);
            cyc(1, 0, 32'h203, 4'h1, u[0], 32'h0, 1, 32'h80FFFFFF);
            chk("ldb_req", bus_req_o, 1);
            chk("ldb_addr", bus_addr_o, 32'h200);
            chk("ldb_hold_ack", hold_o, 0);
            idle_cyc(0, 32'h0);
            chk("ldb_rdata", rdata_o, u == 0 ? 32'hFFFFFF80 : 32'h00000080);
            chk("ldb_vld", rdata_vld_o, 1);
        end

        // Half store to lane 2; inputs scrambled mid-transaction
        sync_idle();
        cyc(0, 1, 32'h302, 4'h3, 0, 32'h1234, 0, 32'h0);
        chk("sth_hold_idle", hold_o, 1);
        cyc(0, 1, 32'h7FF, 4'hF, 0, 32'hAAAA5555, 0, 32'h0);
        chk("sth_be", bus_be_o, 4'hC);
        chk("sth_wdata", bus_wdata_o, 32'h12340000);
        chk("sth_we", bus_we_o, 1);
        chk("sth_hold", hold_o, 1);
        cyc(0, 1, 32'h7FF, 4'hF, 0, 32'hAAAA5555, 1, 32'h0);
        chk("sth_hold_ack", hold_o, 0);
        idle_cyc(0, 32'h0);
        chk("sth_done_req", bus_req_o, 0);

        // Misaligned word load
        sync_idle();
        cyc(1, 0, 32'h401, 4'hF, 0, 32'h0, 0, 32'h0);
        chk("mis_req0", bus_req_o, 0);
        chk("mis_hold0", hold_o, 1);
        cyc(1, 0, 32'h401, 4'hF, 0, 32'h0, 0, 32'h0);
        chk("mis_err", err_o, 1);
        chk("mis_req1", bus_req_o, 0);
        chk("mis_hold1", hold_o, 0);
        idle_cyc(0, 32'h0);
        chk("mis_err_pulse", err_o, 0);
        chk("mis_req2", bus_req_o, 0);

        // Load arriving during a fetch that never gets acked
        sync_idle();
        idle_cyc(0, 32'h0);
        for (int i = 1; i <= 255; i++) begin
            cyc(1, 0, 32'h500, 4'hF, 0, 32'h0, 0, 32'h0);
            if (i == 255) begin
                chk("to_req_last", bus_req_o, 1);
                chk("to_hold", hold_o, 1);
            end
        end
        cyc(1, 0, 32'h500, 4'hF, 0, 32'h0, 0, 32'h0);
        chk("to_err", err_o, 1);
        chk("to_req_dropped", bus_req_o, 0);
        chk("to_vld", inst_vld_o, 0);
        cyc(1, 0, 32'h500, 4'hF, 0, 32'h0, 0, 32'h0);
        chk("to_load_req", bus_req_o, 1);
        chk("to_load_we", bus_we_o, 0);
        chk("to_load_addr", bus_addr_o, 32'h500);
        cyc(1, 0, 32'h500, 4'hF, 0, 32'h0, 1, 32'hCAFE0001);
        idle_cyc(0, 32'h0);
        chk("to_load_rdata", rdata_o, 32'hCAFE0001);

        // Reset asserted in the middle of a store
        sync_idle();
        cyc(0, 1, 32'h600, 4'hF, 0, 32'hDEADBEEF, 0, 32'h0);
        @(posedge clk); #1;
        chk("rs_store_req", bus_req_o, 1);
        #1 rst = 1'b0;
        #1;
        chk("rs_req_now", bus_req_o, 0);
        chk("rs_hold_now", hold_o, 0);
        @(negedge clk);
        idle_cyc(0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; mem_we = 0; bus_ack = 0;
        @(negedge clk);
        chk("rs_idle", bus_req_o, 0);
        idle_cyc(1, 32'h12345678);
        chk("rs_fetch_req", bus_req_o, 1);
        chk("rs_fetch_addr", bus_addr_o, 32'h100);
        idle_cyc(0, 32'h0);
        chk("rs_fetch_inst", inst_o, 32'h12345678);

        // Random traffic including occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) != 0);
            mem_re    = ($urandom_range(0, 9) < 3);
            mem_we    = ($urandom_range(0, 9) < 2);
            addr      = $urandom;
            byte_mask = masks[$urandom_range(0, 2)];
            un_sign   = 1'($urandom_range(0, 1));
            wdata     = $urandom;
            inst_addr = $urandom;
            bus_ack   = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            @(negedge clk);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
